// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache; hits complete in the request cycle.
// Misses stall the CPU while a req/ack writeback of the dirty victim and a line refill run off-chip.
module dcache_ctrl #(
  parameter int INDEX_BITS = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 27 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_READMISS,
    S_REFILL_DONE
  } state_t;

  state_t r_state, w_next;

  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [255:0]          r_data [LINES];
  logic [INDEX_BITS-1:0] r_miss_idx;
  logic [TAG_BITS-1:0]   r_miss_tag;

  logic [2:0]            w_word;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_req, w_hit, w_idle;
  logic                  w_wr_hit, w_miss_start, w_ack_wb, w_ack_rm;
  logic                  w_unused;

  assign w_word   = p1_addr_i[4:2];
  assign w_idx    = p1_addr_i[4+INDEX_BITS:5];
  assign w_tag    = p1_addr_i[31:5+INDEX_BITS];
  assign w_unused = ^p1_addr_i[1:0];

  assign w_req  = p1_MemRead_i | p1_MemWrite_i;
  assign w_hit  = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_idle = (r_state == S_IDLE);

  assign w_wr_hit     = w_idle & w_hit & p1_MemWrite_i;
  assign w_miss_start = w_idle & w_req & ~w_hit;
  assign w_ack_wb     = (r_state == S_WRITEBACK) & mem_ack_i;
  assign w_ack_rm     = (r_state == S_READMISS) & mem_ack_i;

  assign p1_stall_o = ~w_idle | (w_req & ~w_hit);
  assign p1_data_o  = (w_hit & ~p1_MemWrite_i) ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'h0;

  // Memory-side outputs come only from registered state and the index/tag latched at miss entry.
  always_comb begin
    w_next       = r_state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'h0;
    mem_data_o   = 256'h0;
    unique case (r_state)
      S_IDLE: begin
        if (w_miss_start) w_next = S_MISS;
      end
      S_MISS: begin
        if (r_valid[r_miss_idx] & r_dirty[r_miss_idx]) w_next = S_WRITEBACK;
        else                                           w_next = S_READMISS;
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[r_miss_idx], r_miss_idx, 5'b0};
        mem_data_o   = r_data[r_miss_idx];
        if (mem_ack_i) w_next = S_READMISS;
      end
      S_READMISS: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_miss_tag, r_miss_idx, 5'b0};
        if (mem_ack_i) w_next = S_REFILL_DONE;
      end
      S_REFILL_DONE: w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss_start) begin
        r_miss_idx <= w_idx;
        r_miss_tag <= w_tag;
      end
      if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      if (w_ack_wb) r_dirty[r_miss_idx] <= 1'b0;
      if (w_ack_rm) begin
        r_valid[r_miss_idx] <= 1'b1;
        r_dirty[r_miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays keep their contents across reset; the cleared valid bits hide them.
  always_ff @(posedge clk_i) begin
    if (w_wr_hit) r_data[w_idx][{w_word, 5'b0} +: 32] <= p1_data_i;
    if (w_ack_rm) begin
      r_data[r_miss_idx] <= mem_data_i;
      r_tag[r_miss_idx]  <= r_miss_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold/conflict misses, write hit, write allocate, reset mid-writeback.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i, p1_data_i;
  logic         p1_MemRead_i, p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;

  int nvec = 0;
  int nerr = 0;
  int nreq;
  int stalls;
  logic [31:0]  req_addr [4];
  logic         req_wr   [4];
  logic [255:0] req_dat  [4];

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.INDEX_BITS(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
    return l;
  endfunction

  // Memory model: writes ack on their first cycle, reads on cycle rd_delay; counts stalled cycles.
  task automatic serve(input int rd_delay, input logic [255:0] fill);
    int wait_n = 0;
    int c = 0;
    stalls = 0;
    nreq = 0;
    while (p1_stall_o && c < 60) begin
      c++;
      stalls++;
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        if (wait_n == 0 && nreq < 4) begin
          req_addr[nreq] = mem_addr_o;
          req_wr[nreq]   = mem_write_o;
          req_dat[nreq]  = mem_data_o;
        end
        wait_n++;
        if (wait_n >= (mem_write_o ? 1 : rd_delay)) begin
          mem_ack_i  = 1'b1;
          mem_data_i = fill;
          wait_n     = 0;
          nreq++;
        end
      end
      nxt();
    end
    mem_ack_i = 1'b0;
    chk("stall_released", 32'(p1_stall_o), 32'h0);
  endtask

  initial begin
    rst_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    #12;
    chk("rst_stall",  32'(p1_stall_o),   32'h0);
    chk("rst_enable", 32'(mem_enable_o), 32'h0);
    chk("rst_write",  32'(mem_write_o),  32'h0);
    chk("rst_addr",   mem_addr_o,        32'h0);
    chk("rst_rdata",  p1_data_o,         32'h0);
    nxt();
    rst_i = 1'b1;
    nxt();

    // Cold read, ack on second READMISS cycle
    p1_MemRead_i = 1'b1; p1_addr_i = 32'h0000_0008; #1;
    chk("cold_c0_stall", 32'(p1_stall_o), 32'h1);
    serve(2, mkline(32'h1000));
    chk("cold_nreq",   nreq,              32'd1);
    chk("cold_addr",   req_addr[0],       32'h0);
    chk("cold_wr",     32'(req_wr[0]),    32'h0);
    chk("cold_stalls", stalls,            32'd5);
    chk("cold_rdata",  p1_data_o,         32'h1002);

    // Write hit
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b1;
    p1_addr_i = 32'h0000_000C; p1_data_i = 32'hDEAD_BEEF; #1;
    chk("wrhit_stall",  32'(p1_stall_o),   32'h0);
    chk("wrhit_enable", 32'(mem_enable_o), 32'h0);
    nxt();
    p1_MemWrite_i = 1'b0; p1_MemRead_i = 1'b1; #1;
    chk("wrhit_readback", p1_data_o, 32'hDEAD_BEEF);
    p1_addr_i = 32'h0000_0008; #1;
    chk("wrhit_neighbour", p1_data_o, 32'h1002);

    // Dirty conflict on index 0
    p1_addr_i = 32'h0000_0400; #1;
    serve(1, mkline(32'h4000));
    chk("dirty_nreq",   nreq,                  32'd2);
    chk("dirty_wb_wr",  32'(req_wr[0]),        32'h1);
    chk("dirty_wb_addr", req_addr[0],          32'h0);
    chk("dirty_wb_w3",  req_dat[0][127:96],    32'hDEAD_BEEF);
    chk("dirty_wb_w2",  req_dat[0][95:64],     32'h1002);
    chk("dirty_rd_wr",  32'(req_wr[1]),        32'h0);
    chk("dirty_rd_addr", req_addr[1],          32'h400);
    chk("dirty_stalls", stalls,                32'd5);
    chk("dirty_rdata",  p1_data_o,             32'h4000);

    // Clean conflict back to 0x0
    p1_addr_i = 32'h0000_0000; #1;
    serve(1, mkline(32'h2000));
    chk("clean_nreq",   nreq,           32'd1);
    chk("clean_wr",     32'(req_wr[0]), 32'h0);
    chk("clean_addr",   req_addr[0],    32'h0);
    chk("clean_stalls", stalls,         32'd4);
    chk("clean_rdata",  p1_data_o,      32'h2000);

    // Write miss allocate at 0x24
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b1;
    p1_addr_i = 32'h0000_0024; p1_data_i = 32'h55; #1;
    serve(1, mkline(32'h3000));
    chk("wmiss_nreq",   nreq,           32'd1);
    chk("wmiss_addr",   req_addr[0],    32'h20);
    chk("wmiss_wr",     32'(req_wr[0]), 32'h0);
    chk("wmiss_stalls", stalls,         32'd4);
    nxt();
    p1_MemWrite_i = 1'b0; p1_MemRead_i = 1'b1; #1;
    chk("wmiss_w1", p1_data_o, 32'h55);
    p1_addr_i = 32'h0000_0020; #1;
    chk("wmiss_w0", p1_data_o, 32'h3000);
    p1_addr_i = 32'h0000_0420; #1;
    serve(1, mkline(32'h5000));
    chk("wmiss_wb_wr",   32'(req_wr[0]),   32'h1);
    chk("wmiss_wb_addr", req_addr[0],      32'h20);
    chk("wmiss_wb_w1",   req_dat[0][63:32], 32'h55);
    chk("wmiss_wb_w0",   req_dat[0][31:0],  32'h3000);
    chk("wmiss_rd_addr", req_addr[1],      32'h420);
    chk("wmiss_stalls2", stalls,           32'd5);

    // Reset while in WRITEBACK
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b1;
    p1_addr_i = 32'h0000_0424; p1_data_i = 32'h77; #1;
    chk("rstwb_dirty_hit", 32'(p1_stall_o), 32'h0);
    nxt();
    p1_MemWrite_i = 1'b0; p1_MemRead_i = 1'b1; p1_addr_i = 32'h0000_0020; #1;
    nxt();
    nxt();
    chk("rstwb_enable",   32'(mem_enable_o), 32'h1);
    chk("rstwb_write",    32'(mem_write_o),  32'h1);
    chk("rstwb_addr",     mem_addr_o,        32'h420);
    rst_i = 1'b0; #1;
    chk("rstwb_async_en", 32'(mem_enable_o), 32'h0);
    chk("rstwb_async_wr", 32'(mem_write_o),  32'h0);
    chk("rstwb_async_ad", mem_addr_o,        32'h0);
    p1_MemRead_i = 1'b0; #1;
    chk("rstwb_stall",    32'(p1_stall_o),   32'h0);
    nxt();
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    nxt();
    mem_ack_i = 1'b0; #1;
    chk("late_ack_enable", 32'(mem_enable_o), 32'h0);
    chk("late_ack_stall",  32'(p1_stall_o),   32'h0);
    p1_MemRead_i = 1'b1; p1_addr_i = 32'h0000_0420; #1;
    chk("post_rst_miss1", 32'(p1_stall_o), 32'h1);
    chk("post_rst_rdata", p1_data_o,       32'h0);
    p1_addr_i = 32'h0000_0000; #1;
    chk("post_rst_miss0", 32'(p1_stall_o), 32'h1);
    p1_MemRead_i = 1'b0;
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller. It is the responder to the pipeline's MEM-stage data accesses and replaces the single-cycle data memory. Hits complete in the same cycle. Misses stall the pipeline while the controller runs a request/acknowledge transaction with off-chip memory to write back a dirty victim and refill the line.

## Interface
Parameters:
- INDEX_BITS, 5, line index width; 2^INDEX_BITS lines of 256 bits (8 words); tag width = 27 - INDEX_BITS.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- p1_addr_i  in  32  CPU byte address (EX_MEM ALU result); [4:2] word, [4+INDEX_BITS:5] index, [31:5+INDEX_BITS] tag.
- p1_data_i  in  32  CPU store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; wins if both are high.
- p1_data_o  out  32  load data, combinational.
- p1_stall_o  out  1  freeze pipeline, combinational.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  32  line-aligned address, [4:0] = 0.
- mem_data_o  out  256  write-back line data.
- mem_data_i  in  256  refill line, valid only in the mem_ack_i cycle.
- mem_ack_i  in  1  one-cycle completion pulse.

## Operation
- Per line: valid, dirty, tag, 256-bit data. The word is selected by addr[4:2]; word 0 is bits [31:0].
- Request: req = p1_MemRead_i | p1_MemWrite_i.
- Hit: req & valid[idx] & (tag[idx] == addr tag).
- p1_stall_o = (state != IDLE) | (req & ~hit).
- p1_data_o = selected word on a read hit, otherwise 0.
- States:
  - IDLE:
    - Read hit: no state change.
    - Write hit: at the edge, write the word and set dirty.
    - Miss: go to MISS.
  - MISS: if the victim is valid & dirty, go to WRITEBACK; else go to READMISS.
  - WRITEBACK:
    - Drives mem_enable_o=1, mem_write_o=1.
    - mem_addr_o = {victim tag, idx, 5'b0}; mem_data_o = victim line.
    - On mem_ack_i: clear dirty and go to READMISS.
  - READMISS:
    - Drives mem_enable_o=1, mem_write_o=0, mem_addr_o = {req tag, idx, 5'b0}.
    - On mem_ack_i: load mem_data_i, set tag, valid=1, dirty=0, go to REFILL_DONE.
  - REFILL_DONE: go to IDLE unconditionally. The still-held request then hits in IDLE; a write miss completes as a write hit there (write-allocate).
- Outputs in IDLE, MISS and REFILL_DONE: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
- Memory protocol:
  - A new request begins in any cycle with mem_enable_o high that is the first cycle after reset/idle or the cycle after an ack.
  - Address, data and write are stable from request start until ack.
  - Ack in WRITEBACK followed by READMISS gives back-to-back requests with enable held high; memory must treat each ack as ending one request.
  - mem_ack_i outside WRITEBACK/READMISS is ignored.
- The CPU holds address, data and control stable while p1_stall_o=1. Changes during a miss are undefined, except that the index and tag are latched at MISS entry for the whole miss.
- Reset:
  - Asynchronous; all valid and dirty bits cleared, state = IDLE, all mem_* outputs 0 immediately.
  - An in-flight memory transaction is abandoned; a late ack is ignored.
  - Tag and data arrays are not cleared.

## Timing
- Read or write hit: 0 stall cycles; the write lands at the request-cycle edge.
- Clean miss, ack in the first READMISS cycle:
  - C0 IDLE stall, C1 MISS, C2 READMISS with ack, C3 REFILL_DONE, C4 IDLE hit with p1_stall_o=0.
  - Total 4 stall cycles, +1 per cycle of ack delay.
- Dirty miss: adds WRITEBACK cycles, 1 + writeback ack delay.
- p1_data_o and p1_stall_o are combinational from state, arrays and CPU inputs.
- All mem_* outputs are decoded from the registered state plus the latched index/tag only.

## Test plan
- Cold read:
  - Stimulus: reset; p1_MemRead_i=1, addr 0x00000008; memory acks READMISS on its 2nd cycle with line word k = 0x1000+k.
  - Required: mem_addr_o=0x0, mem_write_o=0, 5 stall cycles, then p1_data_o=0x1002 with stall 0.
- Write hit:
  - Stimulus: after the cold read, write 0xDEADBEEF to 0x0000000C.
  - Required: no stall, no mem_enable_o; a following read of 0xC returns 0xDEADBEEF.
- Dirty conflict:
  - Stimulus: read 0x00000400 (INDEX_BITS=5, same index 0).
  - Required: WRITEBACK to addr 0x0 with mem_data_o word 3 = 0xDEADBEEF, then READMISS to addr 0x400, then hit.
- Clean conflict:
  - Stimulus: read 0x00000000 again; line 0x400 is clean.
  - Required: no write request; READMISS to 0x0 only; stall count 4 with immediate ack.
- Write miss allocate:
  - Stimulus: write 0x55 to 0x00000024, cold.
  - Required: refill of 0x20, then word 1 = 0x55 and line dirty (verified by a later conflict writeback).
- Reset mid-WRITEBACK:
  - Stimulus: drop rst_i while mem_enable_o=1.
  - Required: mem_enable_o=0 asynchronously, p1_stall_o=0 with no request, a later ack is ignored, and all lines miss afterwards.
